mmu_initiator: RTL and testbench
================================

# mmu_initiator

Transaction initiator that drives the packet-memory MMU's start/rw_ena/addr/frame/wr_data interface from the packet-switch side. It accepts one command per packet block. For a write, it pops one block of words from a first-word-fall-through ingress FIFO and streams them to the MMU. For a read, it streams one block out of the MMU and returns it with valid/last strobes. It sequences the start window and the inter-transaction gap so the MMU re-arms between packets.

## Interface
- DATA_BIT, 8, data word width
- LOGIC_ADDR_BIT, 3, packet (logical) address width
- FRAME_BIT, 2, frame-count field width
- PKT_WORDS, 8, words per SRAM block (power of two)
- RD_LAT, 3, cycles from the first start-high cycle to the first valid word on mmu_rd_data
- GAP_CYC, 2, minimum start-low cycles between transactions (≥1)

- clk  in  1  clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  LOGIC_ADDR_BIT  packet address
- cmd_frame  in  FRAME_BIT  frame count forwarded to the MMU
- wr_avail  in  1  ingress FIFO holds ≥ PKT_WORDS words
- wr_data  in  DATA_BIT  ingress FIFO head word (FWFT)
- wr_pop  out  1  pop the ingress FIFO head
- rd_valid  out  1  rd_data_out valid
- rd_last  out  1  last word of the read block
- rd_data_out  out  DATA_BIT  read word
- mmu_start  out  1  MMU start
- mmu_rw_ena  out  1  MMU read/write select
- mmu_addr  out  LOGIC_ADDR_BIT  MMU logical address
- mmu_frame  out  FRAME_BIT  MMU frame count
- mmu_wr_data  out  DATA_BIT  MMU write data
- mmu_rd_data  in  DATA_BIT  MMU read data
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at transaction end

## Operation
- FSM states: IDLE, XFER, GAP. Counters:
  - beat: width clog2(PKT_WORDS+RD_LAT)+1
  - gap: width clog2(GAP_CYC)+1
- IDLE:
  - cmd_ready = cmd_rw | wr_avail; a write command is never accepted unless a full block is present.
  - On accept, register cmd_rw/addr/frame into mmu_rw_ena/mmu_addr/mmu_frame. These stay stable until the next accept.
  - Clear beat and go to XFER.
- XFER:
  - mmu_start = 1.
  - Lasts exactly PKT_WORDS+RD_LAT cycles (beat 0 .. PKT_WORDS+RD_LAT-1), then go to GAP.
- Write beats:
  - For beat < PKT_WORDS: wr_pop = 1 and mmu_wr_data = wr_data (combinational pass-through).
  - Otherwise wr_pop = 0 and mmu_wr_data = 0.
  - Exactly PKT_WORDS pops per write.
- Read beats:
  - For RD_LAT ≤ beat < RD_LAT+PKT_WORDS, register mmu_rd_data into rd_data_out and set rd_valid the following cycle.
  - rd_last accompanies the PKT_WORDS-th valid word.
  - wr_pop is never asserted during a read.
- GAP:
  - mmu_start = 0 for GAP_CYC cycles.
  - done = 1 on the final GAP cycle, then go to IDLE.
- mmu_wr_data = 0 whenever state ≠ XFER or mmu_rw_ena = 1.
- wr_avail dropping during XFER is ignored; the FIFO contract guarantees the block.
- The cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values:
  - All outputs are 0 (including cmd_ready).
  - State is IDLE; counters are 0.
  - cmd_ready rises on the first clock after reset release, if its condition holds.
- The following cycles use default parameters; the command is accepted at edge T.
  - mmu_start is high for cycles T+1 .. T+11 (11 cycles).
  - Write: wr_pop is high T+1 .. T+8; word k appears on mmu_wr_data at cycle T+1+k.
  - Read: mmu_rd_data is sampled T+4 .. T+11; rd_valid is high T+5 .. T+12; rd_last is at T+12.
  - GAP covers T+12 .. T+13; done pulses at T+13; cmd_ready is high again at T+14.
- Back-to-back throughput: one block per PKT_WORDS+RD_LAT+GAP_CYC+1 cycles (14 with defaults).
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronous) and no further pops occur. A partially popped block is not restored; upper layers must flush the FIFO.
- rd_valid may overlap GAP. It never overlaps the next transaction's XFER, because the next accept comes after GAP.

## Test plan
- Single write: wr_avail = 1, FIFO words 0x10..0x17, cmd addr = 3, frame = 1, rw = 0.
  - Expect exactly 8 pops at T+1..T+8 with mmu_wr_data 0x10..0x17 in order.
  - Expect mmu_start high for 11 cycles, mmu_addr = 3, mmu_frame = 1, and done at T+13.
- Single read: cmd rw = 1, addr = 3; the model returns 0xA0..0xA7 on mmu_rd_data at T+4..T+11.
  - Expect rd_valid at T+5..T+12 with data 0xA0..0xA7, rd_last only at T+12, and wr_pop never high.
- Write gated: cmd_valid = 1, rw = 0, wr_avail = 0 for 5 cycles.
  - Expect cmd_ready = 0 and mmu_start = 0 throughout.
  - When wr_avail rises, expect accept the same cycle and mmu_start the next cycle.
- Back-to-back write then read with cmd_valid held high.
  - Expect a 2-cycle start-low gap between them, second accept at T+14, and no overlap of rd_valid with the write's pops.
- Reset mid-write: assert rst_n low at T+4.
  - Expect all outputs 0 immediately and no pops afterwards.
  - After release, expect cmd_ready = 1 and a new write to complete normally with 8 pops.
- Command fields changing during XFER (addr 3 → 6 at T+3).
  - Expect mmu_addr to remain 3 for the whole transaction.

Source files
------------

// File: rtl/mmu_initiator.sv
// Packet-switch side initiator for the packet-memory MMU: one command moves one
// block, writes drain the ingress FIFO and reads stream back with valid/last strobes.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready offered once armed after reset
// XFER  | mmu_start high; write beats pop the FIFO, read beats capture mmu_rd_data
// GAP   | mmu_start low so the MMU re-arms; done on the last cycle
module mmu_initiator #(
    parameter int DATA_BIT       = 8,
    parameter int LOGIC_ADDR_BIT = 3,
    parameter int FRAME_BIT      = 2,
    parameter int PKT_WORDS      = 8,
    parameter int RD_LAT         = 3,
    parameter int GAP_CYC        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rw,
    input  logic [LOGIC_ADDR_BIT-1:0] cmd_addr,
    input  logic [FRAME_BIT-1:0]      cmd_frame,
    input  logic                      wr_avail,
    input  logic [DATA_BIT-1:0]       wr_data,
    output logic                      wr_pop,
    output logic                      rd_valid,
    output logic                      rd_last,
    output logic [DATA_BIT-1:0]       rd_data_out,
    output logic                      mmu_start,
    output logic                      mmu_rw_ena,
    output logic [LOGIC_ADDR_BIT-1:0] mmu_addr,
    output logic [FRAME_BIT-1:0]      mmu_frame,
    output logic [DATA_BIT-1:0]       mmu_wr_data,
    input  logic [DATA_BIT-1:0]       mmu_rd_data,
    output logic                      busy,
    output logic                      done
);

    localparam int XFER_CYC = PKT_WORDS + RD_LAT;
    localparam int BEAT_W   = $clog2(XFER_CYC) + 1;
    localparam int GAP_W    = $clog2(GAP_CYC) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [BEAT_W-1:0] BEAT_LAST     = BEAT_W'(XFER_CYC - 1);
    localparam logic [BEAT_W-1:0] BEAT_WR_END   = BEAT_W'(PKT_WORDS);
    localparam logic [BEAT_W-1:0] BEAT_RD_FIRST = BEAT_W'(RD_LAT);
    localparam logic [BEAT_W-1:0] BEAT_ONE      = BEAT_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD      = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE       = GAP_W'(1);

    logic [1:0]                state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      armed_q;
    logic                      rw_q, rw_d;
    logic [LOGIC_ADDR_BIT-1:0] addr_q, addr_d;
    logic [FRAME_BIT-1:0]      frame_q, frame_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rd_last_q, rd_last_d;
    logic [DATA_BIT-1:0]       rd_data_q, rd_data_d;

    logic in_idle, in_xfer, in_gap;
    logic accept;
    logic wr_beat, rd_beat;

    assign in_idle = (state_q == ST_IDLE);
    assign in_xfer = (state_q == ST_XFER);
    assign in_gap  = (state_q == ST_GAP);

    // armed_q holds cmd_ready low until the first clock after reset release
    assign cmd_ready = armed_q & in_idle & (cmd_rw | wr_avail);
    assign accept    = cmd_valid & cmd_ready;

    // The read window always ends on the last XFER beat since XFER_CYC = RD_LAT + PKT_WORDS
    assign wr_beat = in_xfer & ~rw_q & (beat_q < BEAT_WR_END);
    assign rd_beat = in_xfer & rw_q & (beat_q >= BEAT_RD_FIRST);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_XFER;
                    beat_d  = '0;
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr;
                    frame_d = cmd_frame;
                end
            end
            ST_XFER: begin
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_valid_d = rd_beat;
        rd_last_d  = rd_beat & (beat_q == BEAT_LAST);
        rd_data_d  = rd_beat ? mmu_rd_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            gap_q      <= '0;
            armed_q    <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            frame_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            armed_q    <= 1'b1;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            frame_q    <= frame_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_pop      = wr_beat;
    assign mmu_wr_data = wr_beat ? wr_data : '0;
    assign mmu_start   = in_xfer;
    assign mmu_rw_ena  = rw_q;
    assign mmu_addr    = addr_q;
    assign mmu_frame   = frame_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_data_out = rd_data_q;
    assign busy        = ~in_idle;
    assign done        = in_gap & (gap_q == '0);

endmodule

// File: tb/tb_mmu_initiator.sv
// Bench for mmu_initiator: a transaction-timeline reference model (cycles since accept)
// checked every cycle, plus directed sequences and a randomized phase.
module tb_mmu_initiator;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int FW = 2;
    localparam int PW = 8;
    localparam int RL = 3;
    localparam int GC = 2;
    localparam int XK = PW + RL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [FW-1:0] cmd_frame;
    logic          wr_avail;
    logic [DW-1:0] wr_data;
    logic          wr_pop;
    logic          rd_valid;
    logic          rd_last;
    logic [DW-1:0] rd_data_out;
    logic          mmu_start;
    logic          mmu_rw_ena;
    logic [AW-1:0] mmu_addr;
    logic [FW-1:0] mmu_frame;
    logic [DW-1:0] mmu_wr_data;
    logic [DW-1:0] mmu_rd_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mmu_initiator #(
        .DATA_BIT(DW), .LOGIC_ADDR_BIT(AW), .FRAME_BIT(FW),
        .PKT_WORDS(PW), .RD_LAT(RL), .GAP_CYC(GC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_frame(cmd_frame),
        .wr_avail(wr_avail), .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_data_out(rd_data_out),
        .mmu_start(mmu_start), .mmu_rw_ena(mmu_rw_ena), .mmu_addr(mmu_addr),
        .mmu_frame(mmu_frame), .mmu_wr_data(mmu_wr_data), .mmu_rd_data(mmu_rd_data),
        .busy(busy), .done(done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: m_k counts cycles since the accepting cycle (0 = idle).
    logic [DW-1:0] fifo[$];
    int            m_k = 0;
    logic          m_rw = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [FW-1:0] m_frame = '0;
    logic          m_armed = 1'b0;
    logic [DW-1:0] m_base = '0;
    logic [DW-1:0] rd_base_next = 8'hA0;
    logic          force_en = 1'b0;
    logic          force_val = 1'b0;

    logic          s_ready, s_start, s_pop, s_rv, s_rl, s_done, s_busy, prev_start;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    int            cnt_pop, cnt_start, cnt_rv, cnt_rl, cnt_done, cnt_overlap, cnt_gapc;
    int            cyc_no = 0;
    int            rise_q[$];
    logic [DW-1:0] wd_log[$];

    typedef struct {
        logic cv;
        logic rw;
        logic avail;
        logic exp_ready;
        logic exp_start;
    } gate_vec_t;
    gate_vec_t gv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_env();
        wr_avail = force_en ? force_val : (fifo.size() >= PW);
        wr_data  = (fifo.size() > 0) ? fifo[0] : DW'($urandom);
        if (m_rw && m_k >= RL + 1 && m_k <= XK)
            mmu_rd_data = m_base + DW'(m_k - RL - 1);
        else
            mmu_rd_data = DW'($urandom);
    endtask

    task automatic clear_counts();
        cnt_pop = 0; cnt_start = 0; cnt_rv = 0; cnt_rl = 0;
        cnt_done = 0; cnt_overlap = 0; cnt_gapc = 0;
        rise_q.delete();
        wd_log.delete();
    endtask

    task automatic cyc();
        logic          e_ready, e_start, e_pop, e_rv, e_rl, e_done, e_busy;
        logic [DW-1:0] e_wd;
        drive_env();
        @(negedge clk);
        e_busy  = (m_k != 0);
        e_start = (m_k >= 1 && m_k <= XK);
        e_pop   = !m_rw && m_k >= 1 && m_k <= PW;
        e_wd    = (e_pop && fifo.size() > 0) ? fifo[0] : '0;
        e_rv    = m_rw && m_k >= RL + 2 && m_k <= XK + 1;
        e_rl    = m_rw && (m_k == XK + 1);
        e_done  = (m_k == XK + GC);
        e_ready = rst_n && m_armed && (m_k == 0) && (cmd_rw || wr_avail);
        chk("cmd_ready", cmd_ready, e_ready);
        chk("mmu_start", mmu_start, e_start);
        chk("wr_pop", wr_pop, e_pop);
        chk("mmu_wr_data", mmu_wr_data, e_wd);
        chk("rd_valid", rd_valid, e_rv);
        chk("rd_last", rd_last, e_rl);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("mmu_rw_ena", mmu_rw_ena, m_rw);
        chk("mmu_addr", mmu_addr, m_addr);
        chk("mmu_frame", mmu_frame, m_frame);
        if (e_rv) chk("rd_data_out", rd_data_out, m_base + DW'(m_k - RL - 2));
        s_ready = cmd_ready; s_start = mmu_start; s_pop = wr_pop; s_rv = rd_valid;
        s_rl = rd_last; s_done = done; s_busy = busy; s_addr = mmu_addr; s_wd = mmu_wr_data;
        if (s_pop) begin cnt_pop++; wd_log.push_back(s_wd); end
        if (s_start) cnt_start++;
        if (s_rv) cnt_rv++;
        if (s_rl) cnt_rl++;
        if (s_done) cnt_done++;
        if (s_pop && s_rv) cnt_overlap++;
        if (s_busy && !s_start) cnt_gapc++;
        if (s_start && !prev_start) rise_q.push_back(cyc_no);
        prev_start = s_start;
        cyc_no++;
        if (!rst_n) begin
            m_k = 0; m_rw = 1'b0; m_addr = '0; m_frame = '0; m_armed = 1'b0;
        end else begin
            if (e_pop && fifo.size() > 0) void'(fifo.pop_front());
            if (m_k == 0) begin
                if (cmd_valid && e_ready) begin
                    m_k = 1; m_rw = cmd_rw; m_addr = cmd_addr; m_frame = cmd_frame;
                    if (cmd_rw) m_base = rd_base_next;
                end
            end else if (m_k == XK + GC) begin
                m_k = 0;
            end else begin
                m_k++;
            end
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 20 && m_k != 0; i++) cyc();
        chk("idle_wait_bound", (m_k == 0), 1'b1);
    endtask

    task automatic push_block(input logic [DW-1:0] first, input bit rnd);
        for (int i = 0; i < PW; i++) fifo.push_back(rnd ? DW'($urandom) : first + DW'(i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        gv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b1; cmd_addr = '0; cmd_frame = '0;
        wr_avail = 1'b0; wr_data = '0; mmu_rd_data = '0; prev_start = 1'b0;
        clear_counts();

        // Reset: all outputs low, cmd_ready only after the first clock past release
        run(3);
        rst_n = 1'b1;
        cyc();
        chk("ready_first_clk", s_ready, 1'b0);
        cyc();
        chk("ready_armed", s_ready, 1'b1);

        // Single write
        push_block(8'h10, 0);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'd3; cmd_frame = 2'd1;
        cyc();
        cmd_valid = 1'b0;
        clear_counts();
        run(XK + GC);
        chk("wr_pops", cnt_pop, PW);
        chk("wr_start_len", cnt_start, XK);
        chk("wr_done_cnt", cnt_done, 1);
        for (int i = 0; i < PW; i++)
            chk("wr_word", (wd_log.size() > i) ? wd_log[i] : 8'hxx, 8'h10 + DW'(i));

        // Single read
        rd_base_next = 8'hA0;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 3'd3; cmd_frame = 2'd0;
        cyc();
        cmd_valid = 1'b0;
        clear_counts();
        run(XK + GC);
        chk("rd_valid_cnt", cnt_rv, PW);
        chk("rd_last_cnt", cnt_rl, 1);
        chk("rd_no_pop", cnt_pop, 0);

        // Write gated until a full block is present
        push_block(8'h40, 0);
        clear_counts();
        for (int i = 0; i < 7; i++) begin
            cmd_valid = gv[i].cv; cmd_rw = gv[i].rw; cmd_addr = 3'd1;
            force_en = 1'b1; force_val = gv[i].avail;
            cyc();
            chk("gate_ready", s_ready, gv[i].exp_ready);
            chk("gate_start", s_start, gv[i].exp_start);
        end
        force_en = 1'b0; cmd_valid = 1'b0;
        idle_wait();
        chk("gate_pops", cnt_pop, PW);

        // Back-to-back write then read with cmd_valid held
        push_block(8'h60, 0);
        rd_base_next = 8'h55;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'd2; cmd_frame = 2'd3;
        clear_counts();
        cyc();
        cmd_rw = 1'b1; cmd_addr = 3'd4;
        cnt_gapc = 0;
        run(XK + GC + 1);
        chk("b2b_gap_cycles", cnt_gapc, GC);
        cmd_valid = 1'b0;
        idle_wait();
        if (rise_q.size() >= 2) chk("b2b_period", rise_q[1] - rise_q[0], XK + GC + 1);
        else chk("b2b_rises", rise_q.size(), 2);
        chk("b2b_overlap", cnt_overlap, 0);
        chk("b2b_rd_cnt", cnt_rv, PW);

        // Reset during a write at T+4
        push_block(8'h80, 0);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'd5; cmd_frame = 2'd2;
        cyc();
        cmd_valid = 1'b0;
        run(3);
        drive_env();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pop", wr_pop, 1'b0);
        chk("rst_start", mmu_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mmu_addr, 3'd0);
        chk("rst_frame", mmu_frame, 2'd0);
        chk("rst_wdata", mmu_wr_data, 8'd0);
        chk("rst_ready", cmd_ready, 1'b0);
        m_k = 0; m_rw = 1'b0; m_addr = '0; m_frame = '0; m_armed = 1'b0;
        fifo.delete();
        clear_counts();
        run(3);
        chk("rst_no_pops", cnt_pop, 0);
        rst_n = 1'b1;
        cyc();
        push_block(8'h90, 0);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'd7;
        cyc();
        chk("post_rst_accept", s_ready, 1'b1);
        cmd_valid = 1'b0;
        clear_counts();
        idle_wait();
        chk("post_rst_pops", cnt_pop, PW);

        // Command fields change during XFER
        push_block(8'hC0, 0);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 3'd3; cmd_frame = 2'd1;
        cyc();
        cmd_valid = 1'b0;
        run(2);
        cmd_addr = 3'd6; cmd_frame = 2'd2;
        for (int i = 0; i < XK + GC - 2; i++) begin
            cyc();
            chk("hold_addr", s_addr, 3'd3);
        end

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (fifo.size() < PW && $urandom_range(3) == 0) push_block('0, 1);
            cmd_valid    = 1'($urandom_range(1));
            cmd_rw       = 1'($urandom_range(1));
            cmd_addr     = AW'($urandom);
            cmd_frame    = FW'($urandom);
            rd_base_next = DW'($urandom);
            cyc();
        end
        cmd_valid = 1'b0;
        idle_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
